// File: rtl/alu_writeback_ctrl.sv
// Writeback sequencer between the 16-bit ALU and the single-write-port register file.
// Optional forwarding outputs are enabled with ALU_WB_FWD_EN.
module alu_writeback_ctrl #(
    parameter int unsigned    AW     = 4,
    parameter logic [AW-1:0]  HI_REG = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] dest,
    input  logic [AW-1:0] src2,
    input  logic [15:0]   ylow,
    input  logic [15:0]   yhigh,
    input  logic          n_l,
    input  logic          z_l,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [15:0]   rf_wdata,
    output logic          flag_n_l,
    output logic          flag_z_l,
    output logic          busy
`ifdef ALU_WB_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [15:0]   fwd_data
`endif
);

    typedef enum logic [1:0] {StIdle, StWrLo, StWrHi} state_e;

    state_e        state_q;
    logic [2:0]    op_q;
    logic [AW-1:0] dest_q;
    logic [AW-1:0] src2_q;
    logic [15:0]   ylow_q;
    logic [15:0]   yhigh_q;
    logic          hi_pending;
    logic          accept;

    assign hi_pending = (op_q == 3'd2) || (op_q == 3'd3) || (op_q == 3'd4);
    // Holding registers free up while their last write is on the bus.
    assign in_ready   = (state_q == StIdle) || (state_q == StWrHi) ||
                        ((state_q == StWrLo) && !hi_pending);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            dest_q   <= '0;
            src2_q   <= '0;
            ylow_q   <= '0;
            yhigh_q  <= '0;
            flag_n_l <= 1'b1;
            flag_z_l <= 1'b1;
        end else if (accept) begin
            state_q  <= StWrLo;
            op_q     <= op;
            dest_q   <= dest;
            src2_q   <= src2;
            ylow_q   <= ylow;
            yhigh_q  <= yhigh;
            flag_n_l <= n_l;
            flag_z_l <= z_l;
        end else if ((state_q == StWrLo) && hi_pending) begin
            state_q <= StWrHi;
        end else begin
            state_q <= StIdle;
        end
    end

    // Write port is driven from state and holding registers only.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (state_q)
            StWrLo: begin
                rf_we    = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = ylow_q;
            end
            StWrHi: begin
                rf_we    = 1'b1;
                rf_waddr = (op_q == 3'd4) ? src2_q : HI_REG;
                rf_wdata = yhigh_q;
            end
            default: ;
        endcase
    end

`ifdef ALU_WB_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Randomized bench for alu_writeback_ctrl against a write-queue reference model.
module tb_alu_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [3:0]  dest, src2;
    logic [15:0] ylow, yhigh;
    logic        n_l, z_l;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_n_l, flag_z_l, busy;
`ifdef ALU_WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;
`endif

    alu_writeback_ctrl #(.AW(4), .HI_REG(4'd0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dest(dest), .src2(src2), .ylow(ylow), .yhigh(yhigh), .n_l(n_l), .z_l(z_l),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_n_l(flag_n_l), .flag_z_l(flag_z_l), .busy(busy)
`ifdef ALU_WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         q[$];
    logic        m_n, m_z;
    logic [15:0] m_rf [16];
    logic [15:0] d_rf [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, compare after it.
    task automatic step(input logic r, input logic v, input logic [2:0] o, input logic [3:0] d,
                        input logic [3:0] s, input logic [15:0] lo, input logic [15:0] hi,
                        input logic nn, input logic zz);
        logic acc;
        wr_t  w;
        rst = r; in_valid = v; op = o; dest = d; src2 = s;
        ylow = lo; yhigh = hi; n_l = nn; z_l = zz;
        acc = v && !r && (q.size() <= 1);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_n = 1'b1;
            m_z = 1'b1;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                w.a = d;  w.d = lo; q.push_back(w);
                if (o == 3'd2 || o == 3'd3) begin
                    w.a = 4'd0; w.d = hi; q.push_back(w);
                end else if (o == 3'd4) begin
                    w.a = s; w.d = hi; q.push_back(w);
                end
                m_n = nn;
                m_z = zz;
            end
        end
        #1;
        check("rf_we", 32'(rf_we), 32'(q.size() > 0));
        check("rf_waddr", 32'(rf_waddr), (q.size() > 0) ? 32'(q[0].a) : 32'd0);
        check("rf_wdata", 32'(rf_wdata), (q.size() > 0) ? 32'(q[0].d) : 32'd0);
        check("in_ready", 32'(in_ready), 32'(q.size() <= 1));
        check("busy", 32'(busy), 32'(q.size() > 0));
        check("flag_n_l", 32'(flag_n_l), 32'(m_n));
        check("flag_z_l", 32'(flag_z_l), 32'(m_z));
`ifdef ALU_WB_FWD_EN
        check("fwd", {15'd0, fwd_valid, fwd_addr, fwd_data}, {15'd0, rf_we, rf_waddr, rf_wdata});
`endif
        if (q.size() > 0) m_rf[q[0].a] = q[0].d;
        if (rf_we) d_rf[rf_waddr] = rf_wdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    endtask

    initial begin
        m_n = 1'b1;
        m_z = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_rf[i] = 16'h0;
            d_rf[i] = 16'h0;
        end
        step(1'b1, 1'b1, 3'd2, 4'd9, 4'd9, 16'h1234, 16'h5678, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1);
        check("reset_ready", 32'(in_ready), 32'd1);

        // Add
        step(1'b0, 1'b1, 3'd0, 4'd3, 4'd0, 16'h0005, 16'h0, 1'b1, 1'b1);
        idle(2);
        // Mul with HI_REG = 0
        step(1'b0, 1'b1, 3'd2, 4'd5, 4'd0, 16'hFFFE, 16'hFFFF, 1'b0, 1'b1);
        check("mul_wrlo_ready", 32'(in_ready), 32'd0);
        idle(2);
        check("mul_r5", 32'(d_rf[5]), 32'h0000FFFE);
        check("mul_r0", 32'(d_rf[0]), 32'h0000FFFF);
        // Swap, then swap onto itself
        step(1'b0, 1'b1, 3'd4, 4'd1, 4'd2, 16'h00BB, 16'h00AA, 1'b1, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 3'd4, 4'd7, 4'd7, 16'h00BB, 16'h00AA, 1'b1, 1'b1);
        idle(2);
        check("swap_r1", 32'(d_rf[1]), 32'h00BB);
        check("swap_r2", 32'(d_rf[2]), 32'h00AA);
        check("swap_r7", 32'(d_rf[7]), 32'h00AA);
        // Back-to-back single-word results
        step(1'b0, 1'b1, 3'd0, 4'd1, 4'd0, 16'h1111, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'd5, 4'd2, 4'd0, 16'h2222, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'd6, 4'd3, 4'd0, 16'h3333, 16'h0, 1'b1, 1'b1);
        idle(2);
        // Reset aborts a pending divide
        step(1'b0, 1'b1, 3'd3, 4'd4, 4'd0, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1);
        check("rst_abort_we", 32'(rf_we), 32'd0);
        idle(1);
        // Zero flag held through idle cycles
        step(1'b0, 1'b1, 3'd1, 4'd6, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(5);
        check("zflag_held", 32'(flag_z_l), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                 3'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom));
        end
        idle(3);
        for (int i = 0; i < 16; i++) check("rf_final", 32'(d_rf[i]), 32'(m_rf[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
